// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// default timing constants and serial line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEF = 5;
    localparam int unsigned DATA_BITS_DEF    = 8;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done in the terminal-count cycle. Shared with the receiver.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TERM) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bit_done = en && (cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing, valid/ready byte input, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy
);

    localparam int unsigned   BW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic                 tx_out_n;
    logic                 hs;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r;
`endif

    assign tx_ready = (state == IDLE) || ((state == STOP) && bit_done);
    assign hs       = tx_valid && tx_ready;
    assign tx_busy  = (state != IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (hs),
        .en      (tx_busy),
        .bit_done(bit_done)
    );

    // tx_out_n is the level for the cycle after the edge, so the line changes
    // in the same cycle as the state it belongs to.
    always_comb begin
        state_n  = state;
        shift_n  = shift;
        bitcnt_n = bitcnt;
        tx_out_n = tx_out;
        case (state)
            IDLE: begin
                tx_out_n = LINE_IDLE;
            end
            START: begin
                if (bit_done) begin
                    state_n  = DATA;
                    tx_out_n = shift[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_n  = shift >> 1;
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_n  = PARITY;
                        tx_out_n = parity_r;
`else
                        state_n  = STOP;
                        tx_out_n = STOP_LVL;
`endif
                    end else begin
                        tx_out_n = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_n  = STOP;
                    tx_out_n = STOP_LVL;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_n  = IDLE;
                    tx_out_n = LINE_IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                tx_out_n = LINE_IDLE;
            end
        endcase
        // A handshake only happens in IDLE or the last STOP cycle; both start a frame.
        if (hs) begin
            state_n  = START;
            shift_n  = tx_data;
            bitcnt_n = '0;
            tx_out_n = START_LVL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shift  <= '0;
            bitcnt <= '0;
            tx_out <= LINE_IDLE;
        end else begin
            state  <= state_n;
            shift  <= shift_n;
            bitcnt <= bitcnt_n;
            tx_out <= tx_out_n;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (hs) begin
            parity_r <= ^tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line waveform against a frame model,
// back-to-back streaming, busy-time rejection, reset abort, mid-bit decoding.
module tb_uart_tx;

    localparam int CPB = 5;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int FL  = (DB + 2 + PB) * CPB;

    typedef logic [DB-1:0] byte_q_t[$];

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_ready;
    logic          tx_out;
    logic          tx_busy;

    int checks = 0;
    int passed = 0;

    always #10 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    // Expected line level k cycles into the frame carrying d.
    function automatic logic model_bit(input logic [DB-1:0] d, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return d[slot-1];
        if (PB == 1 && slot == DB + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_out, tx_busy, tx_ready} !== 3'b101)
            $display("FAIL reset_hold out/busy/ready=%b expected=101", {tx_out, tx_busy, tx_ready});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_out, tx_busy, tx_ready} !== 3'b101)
            $display("FAIL reset_release out/busy/ready=%b expected=101", {tx_out, tx_busy, tx_ready});
        else passed++;
    endtask

    // Streams bytes with tx_valid held; optionally pulses 0xA5 mid-frame of the last byte.
    task automatic send_stream(input byte_q_t bytes, input string name, input int inject_at);
        int     n;
        int     nxt;
        int     fr;
        int     fi;
        logic   exp;
        n = bytes.size();
        checks++;
        if (tx_ready !== 1'b1) $display("FAIL %s_pre_ready tx_ready=%b expected=1", name, tx_ready);
        else passed++;
        tx_valid = 1'b1;
        tx_data  = bytes[0];
        nxt      = 1;
        for (int k = 0; k < n * FL; k++) begin
            @(negedge clk);
            fr  = k % FL;
            fi  = k / FL;
            exp = model_bit(bytes[fi], fr);
            checks++;
            if (tx_out !== exp)
                $display("FAIL %s_line k=%0d tx_out=%b expected=%b", name, k, tx_out, exp);
            else passed++;
            checks++;
            if ({tx_busy, tx_ready} !== {1'b1, fr == FL - 1})
                $display("FAIL %s_flags k=%0d busy/ready=%b expected=%b", name, k,
                         {tx_busy, tx_ready}, {1'b1, fr == FL - 1});
            else passed++;
            if (fr == 0) begin
                if (nxt < n) begin
                    tx_data = bytes[nxt];
                    nxt++;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = DB'($urandom);
                end
            end
            if (inject_at > 0 && fi == n - 1) begin
                if (fr == inject_at) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'hA5;
                end else if (fr == inject_at + 1) begin
                    tx_valid = 1'b0;
                end
            end
        end
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            checks++;
            if ({tx_out, tx_busy, tx_ready} !== 3'b101)
                $display("FAIL %s_idle k=%0d out/busy/ready=%b expected=101", name, k,
                         {tx_out, tx_busy, tx_ready});
            else passed++;
        end
    endtask

    task automatic test_single;
        byte_q_t q;
        q.push_back(8'h55);
        send_stream(q, "single_55", -1);
        for (int i = 0; i < 3; i++) begin
            q = {};
            q.push_back(DB'($urandom));
            send_stream(q, "single_rand", -1);
        end
    endtask

    task automatic test_back_to_back;
        byte_q_t q;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        send_stream(q, "b2b_00_ff", -1);
        q = {};
        for (int i = 0; i < 3; i++) q.push_back(DB'($urandom));
        send_stream(q, "b2b_rand", -1);
    endtask

    task automatic test_ignore_busy;
        byte_q_t q;
        q.push_back(8'h3C);
        send_stream(q, "ignore_a5", 20);
        q = {};
        q.push_back(DB'($urandom));
        send_stream(q, "ignore_rand", 12);
    endtask

    task automatic test_abort;
        byte_q_t q;
        logic    exp;
        checks++;
        if (tx_ready !== 1'b1) $display("FAIL abort_pre_ready tx_ready=%b expected=1", tx_ready);
        else passed++;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            exp = model_bit(8'h3C, k);
            checks++;
            if (tx_out !== exp) $display("FAIL abort_line k=%0d tx_out=%b expected=%b", k, tx_out, exp);
            else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_out, tx_busy, tx_ready} !== 3'b101)
            $display("FAIL abort_reset out/busy/ready=%b expected=101", {tx_out, tx_busy, tx_ready});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_out, tx_busy, tx_ready} !== 3'b101)
            $display("FAIL abort_idle out/busy/ready=%b expected=101", {tx_out, tx_busy, tx_ready});
        else passed++;
        q.push_back(8'h81);
        send_stream(q, "abort_81", -1);
    endtask

    // Receiver model: hunt for the start edge, then sample each bit mid-period.
    task automatic rx_frame(input logic [DB-1:0] b, input string name, output logic [DB-1:0] d,
                            output logic st, output logic par, output logic sp);
        bit found;
        d = '0; st = 1'b1; par = 1'b0; sp = 1'b0;
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 4 && !found; t++) begin
            if (tx_out === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            $display("FAIL %s_start_timeout tx_out=%b expected=0 within 4 cycles", name, tx_out);
            return;
        end
        passed++;
        repeat (CPB / 2) @(negedge clk);
        st = tx_out;
        for (int i = 0; i < DB; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx_out;
        end
        if (PB == 1) begin
            repeat (CPB) @(negedge clk);
            par = tx_out;
        end
        repeat (CPB) @(negedge clk);
        sp = tx_out;
        repeat (CPB - CPB / 2) @(negedge clk);
    endtask

    task automatic test_loopback;
        logic [DB-1:0] tbl[6];
        logic [DB-1:0] d;
        logic          st, par, sp;
        tbl[0] = 8'h00; tbl[1] = 8'h7E; tbl[2] = 8'hFF; tbl[3] = 8'h96;
        tbl[4] = DB'($urandom); tbl[5] = DB'($urandom);
        for (int i = 0; i < 6; i++) begin
            rx_frame(tbl[i], "loop", d, st, par, sp);
            checks++;
            if (d !== tbl[i]) $display("FAIL loop_data i=%0d got=%h expected=%h", i, d, tbl[i]);
            else passed++;
            checks++;
            if ({st, sp} !== 2'b01)
                $display("FAIL loop_framing i=%0d start/stop=%b expected=01", i, {st, sp});
            else passed++;
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [DB-1:0] d;
        logic          st, par, sp;
        byte_q_t       q;
        rx_frame(8'h07, "par07", d, st, par, sp);
        checks++;
        if (par !== 1'b1) $display("FAIL parity_07 got=%b expected=1", par);
        else passed++;
        checks++;
        if ({d, sp} !== {8'h07, 1'b1}) $display("FAIL parity_07_frame data=%h stop=%b expected=07/1", d, sp);
        else passed++;
        rx_frame(8'h03, "par03", d, st, par, sp);
        checks++;
        if (par !== 1'b0) $display("FAIL parity_03 got=%b expected=0", par);
        else passed++;
        q.push_back(8'h07);
        send_stream(q, "parity_len", -1);
    endtask
`endif

    initial begin
        #(5_000_000);
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_abort();
        test_loopback();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
